// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, parameter limits,
// and the parity helper.
package fifo_uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   localparam int unsigned MIN_CLKS_PER_BIT = 2;
   localparam int unsigned MIN_DATA_BITS    = 2;
   localparam int unsigned MAX_STOP_BITS    = 2;

   // data_xor is the XOR of all data bits; even parity sends it unchanged.
   function automatic logic parity_bit(input logic data_xor, input logic odd);
      return data_xor ^ odd;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and pulses tick on the
// last count of each period; the count is held at zero while run is low.
module baud_tick_gen #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic clrn,
   input  logic run,
   output logic tick
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         cnt <= '0;
      end else if (!run || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign tick = run && (cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a show-ahead FIFO and serialises each popped word as a UART frame
// (start, LSB-first data, optional parity, 1 or 2 stop bits) on a registered txd.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                 clk,
   input  logic                 clrn,
   input  logic                 tx_en,
   input  logic [DATA_BITS-1:0] fifo_data,
   input  logic                 fifo_empty,
   output logic                 fifo_read,
   output logic                 txd,
   output logic                 busy
);

   if (CLKS_PER_BIT < MIN_CLKS_PER_BIT) begin : g_bad_clks
      $error("fifo_uart_tx: CLKS_PER_BIT must be >= 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > MAX_STOP_BITS) begin : g_bad_stop
      $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
   end
   if (DATA_BITS < MIN_DATA_BITS) begin : g_bad_data
      $error("fifo_uart_tx: DATA_BITS must be >= 2");
   end

   localparam int unsigned BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
   localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

   tx_state_t            state, state_next;
   logic [DATA_BITS-1:0] shift_reg;
   logic [DATA_BITS-1:0] data_q;
   logic [BW-1:0]        bit_cnt;
   logic                 stop_cnt;
   logic                 txd_q, txd_next;
   logic                 tick;
   logic                 par;

   baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk  (clk),
      .clrn (clrn),
      .run  (state != IDLE),
      .tick (tick)
   );

   // Gated by clrn so no pop can be issued while the block is held in reset.
   assign fifo_read = clrn && (state == IDLE) && tx_en && !fifo_empty;
   assign par       = parity_bit(^data_q, PARITY_ODD != 0);
   assign busy      = (state != IDLE);
   assign txd       = txd_q;

   // txd_next is the line level for the state being entered, so txd is registered
   // yet changes on the same edge as the state.
   always_comb begin
      state_next = state;
      txd_next   = txd_q;
      case (state)
         IDLE: begin
            txd_next = 1'b1;
            if (fifo_read) begin
               state_next = START;
               txd_next   = 1'b0;
            end
         end
         START: begin
            if (tick) begin
               state_next = DATA;
               txd_next   = shift_reg[0];
            end
         end
         DATA: begin
            if (tick) begin
               if (bit_cnt != LAST_BIT) begin
                  txd_next = shift_reg[1];
               end else if (PARITY_EN != 0) begin
                  state_next = PARITY;
                  txd_next   = par;
               end else begin
                  state_next = STOP;
                  txd_next   = 1'b1;
               end
            end
         end
         PARITY: begin
            if (tick) begin
               state_next = STOP;
               txd_next   = 1'b1;
            end
         end
         STOP: begin
            txd_next = 1'b1;
            if (tick && stop_cnt == LAST_STOP) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
            txd_next   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state     <= IDLE;
         txd_q     <= 1'b1;
         shift_reg <= '0;
         data_q    <= '0;
         bit_cnt   <= '0;
         stop_cnt  <= 1'b0;
      end else begin
         state <= state_next;
         txd_q <= txd_next;
         if (fifo_read) begin
            shift_reg <= fifo_data;
            data_q    <= fifo_data;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
         end else if (tick) begin
            case (state)
               DATA: begin
                  shift_reg <= shift_reg >> 1;
                  bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
               end
               STOP:    stop_cnt <= stop_cnt + 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: a queue-fed FIFO and a frame-level timing model compared every
// cycle, plus directed scenarios, a bit-centre UART receiver and two parity instances.
module tb_fifo_uart_tx;

   localparam int CPB       = 4;
   localparam int FRAME_CYC = 10 * CPB;

   logic       clk = 1'b0;
   logic       clrn, tx_en;
   logic [7:0] fifo_data;
   logic       fifo_empty, fifo_read, txd, busy;

   always #5 clk = ~clk;

   // Upstream show-ahead FIFO; pops are driven by the model's prediction, not by the DUT.
   logic [7:0]  mem [16];
   int unsigned wr = 0;
   int unsigned rd = 0;
   assign fifo_empty = (wr == rd);
   assign fifo_data  = fifo_empty ? 8'hxx : mem[rd[3:0]];

   fifo_uart_tx #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)
   ) dut (
      .clk(clk), .clrn(clrn), .tx_en(tx_en), .fifo_data(fifo_data),
      .fifo_empty(fifo_empty), .fifo_read(fifo_read), .txd(txd), .busy(busy)
   );

   logic       p_empty = 1'b1;
   logic [7:0] p_data  = 8'h07;
   logic [1:0] p_read, p_txd, p_busy;

   fifo_uart_tx #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)
   ) dut_even (
      .clk(clk), .clrn(clrn), .tx_en(1'b1), .fifo_data(p_data),
      .fifo_empty(p_empty), .fifo_read(p_read[0]), .txd(p_txd[0]), .busy(p_busy[0])
   );

   fifo_uart_tx #(
      .DATA_BITS(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)
   ) dut_odd (
      .clk(clk), .clrn(clrn), .tx_en(1'b1), .fifo_data(p_data),
      .fifo_empty(p_empty), .fifo_read(p_read[1]), .txd(p_txd[1]), .busy(p_busy[1])
   );

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Frame-level model: m_left = cycles of the current frame still to be sent.
   int         m_left  = 0;
   logic [9:0] m_frame = '0;
   logic       exp_pop, exp_busy, exp_txd;

   function automatic logic [9:0] mk_frame(input logic [7:0] d);
      return {1'b1, d, 1'b0};
   endfunction

   always_comb begin
      exp_pop  = clrn && (m_left == 0) && tx_en && (wr != rd);
      exp_busy = clrn && (m_left > 0);
      exp_txd  = exp_busy ? m_frame[(FRAME_CYC - m_left) / CPB] : 1'b1;
   end

   always @(posedge clk) begin
      if (!clrn) begin
         m_left <= 0;
      end else if (exp_pop) begin
         m_left  <= FRAME_CYC;
         m_frame <= mk_frame(mem[rd[3:0]]);
         rd      <= rd + 1;
      end else if (m_left > 0) begin
         m_left <= m_left - 1;
      end
   end

   int cyc = 0;
   int dut_pops = 0;
   int busy_cyc = 0;
   int low_cyc  = 0;
   int pop_cyc[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      #2;
      check("fifo_read", int'(fifo_read), int'(exp_pop));
      check("busy", int'(busy), int'(exp_busy));
      check("txd", int'(txd), int'(exp_txd));
      if (fifo_read === 1'b1) begin
         dut_pops++;
         pop_cyc.push_back(cyc);
      end
      if (busy === 1'b1) busy_cyc++;
      if (txd === 1'b0) low_cyc++;
   end

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      mem[wr[3:0]] = d;
      wr++;
   endtask

   // Receiver: find the falling start edge, then sample each bit near its centre.
   task automatic rx_byte(input string name, input logic [7:0] want);
      logic [7:0] b;
      bit         found;
      found = 1'b0;
      b     = '0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(posedge clk);
         #1;
         if (txd == 1'b0) found = 1'b1;
      end
      check({name, "_start_found"}, int'(found), 1);
      if (found) begin
         #16;
         check({name, "_start_bit"}, int'(txd), 0);
         for (int k = 0; k < 8; k++) begin
            #40;
            b[k] = txd;
         end
         #40;
         check({name, "_stop_bit"}, int'(txd), 1);
         check({name, "_byte"}, int'(b), int'(want));
      end
   endtask

   int p0, b0, l0, q0;

   initial begin
      clrn  = 1'b0;
      tx_en = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      check("reset_txd", int'(txd), 1);
      check("reset_busy", int'(busy), 0);
      check("reset_fifo_read", int'(fifo_read), 0);
      @(negedge clk);
      clrn = 1'b1;
      repeat (2) @(negedge clk);

      // Single byte 0x55
      p0 = dut_pops; b0 = busy_cyc;
      push(8'h55);
      rx_byte("t1", 8'h55);
      repeat (10) @(negedge clk);
      check("t1_pops", dut_pops - p0, 1);
      check("t1_busy_cycles", busy_cyc - b0, 40);

      // Empty FIFO, enabled
      p0 = dut_pops; b0 = busy_cyc; l0 = low_cyc;
      repeat (200) @(negedge clk);
      check("t2_pops", dut_pops - p0, 0);
      check("t2_busy_cycles", busy_cyc - b0, 0);
      check("t2_txd_low_cycles", low_cyc - l0, 0);

      // Three queued bytes back to back
      tx_en = 1'b0;
      push(8'hA5); push(8'h3C); push(8'hFF);
      q0 = pop_cyc.size();
      @(negedge clk);
      tx_en = 1'b1;
      rx_byte("t3a", 8'hA5);
      rx_byte("t3b", 8'h3C);
      rx_byte("t3c", 8'hFF);
      repeat (20) @(negedge clk);
      check("t3_pop_count", pop_cyc.size() - q0, 3);
      if (pop_cyc.size() - q0 == 3) begin
         check("t3_spacing_1", pop_cyc[q0+1] - pop_cyc[q0], 41);
         check("t3_spacing_2", pop_cyc[q0+2] - pop_cyc[q0+1], 41);
      end
      check("t3_fifo_empty", int'(fifo_empty), 1);
      check("t3_txd_idle", int'(txd), 1);

      // tx_en dropped mid-frame
      tx_en = 1'b0;
      push(8'h11); push(8'h22);
      p0 = dut_pops;
      @(negedge clk);
      tx_en = 1'b1;
      repeat (10) @(negedge clk);
      tx_en = 1'b0;
      repeat (50) @(negedge clk);
      check("t5_pops_while_disabled", dut_pops - p0, 1);
      check("t5_fifo_level", int'(wr - rd), 1);
      tx_en = 1'b1;
      #2;
      check("t5_pop_on_reenable", int'(fifo_read), 1);
      repeat (50) @(negedge clk);

      // Reset in the middle of a data bit
      tx_en = 1'b0;
      push(8'h81); push(8'h5A);
      @(negedge clk);
      tx_en = 1'b1;
      repeat (16) @(negedge clk);
      check("t6_busy_before_reset", int'(busy), 1);
      clrn = 1'b0;
      #1;
      check("t6_reset_txd", int'(txd), 1);
      check("t6_reset_busy", int'(busy), 0);
      p0 = dut_pops;
      repeat (3) @(negedge clk);
      check("t6_no_pop_in_reset", dut_pops - p0, 0);
      clrn = 1'b1;
      rx_byte("t6", 8'h5A);
      repeat (10) @(negedge clk);

      // Randomised traffic with enable toggling
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 3) tx_en = ~tx_en;
         if ((wr - rd) < 16 && $urandom_range(0, 29) == 0) begin
            mem[wr[3:0]] = 8'($urandom);
            wr++;
         end
      end
      tx_en = 1'b1;
      for (int i = 0; i < 900 && (wr != rd || m_left != 0); i++) @(negedge clk);
      check("rand_drained", int'(wr == rd && m_left == 0), 1);
      repeat (5) @(negedge clk);

      // Parity instances send 0x07: even parity bit 1, odd parity bit 0, 44-clk frame
      begin
         logic [10:0] bits_e, bits_o;
         int          be, bo;
         bits_e = '0; bits_o = '0; be = 0; bo = 0;
         @(negedge clk);
         p_empty = 1'b0;
         #2;
         check("par_pop_even", int'(p_read[0]), 1);
         check("par_pop_odd", int'(p_read[1]), 1);
         for (int j = 0; j < 60; j++) begin
            @(negedge clk);
            if (j == 0) p_empty = 1'b1;
            #2;
            if (p_busy[0]) be++;
            if (p_busy[1]) bo++;
            if (j % CPB == 2 && j / CPB < 11) begin
               bits_e[j / CPB] = p_txd[0];
               bits_o[j / CPB] = p_txd[1];
            end
         end
         check("par_even_frame_cycles", be, 44);
         check("par_odd_frame_cycles", bo, 44);
         check("par_even_bits", int'(bits_e), int'(11'b1_1_00000111_0));
         check("par_odd_bits", int'(bits_o), int'(11'b1_0_00000111_0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      failures++;
      $display("FAIL global_timeout actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
